// File: rtl/fsic_clk_pkg.sv
// Shared definitions for the FSIC clock divider: config FSM encoding,
// the widest supported ratio field and the divided-clock high-phase helper.
package fsic_clk_pkg;

  localparam int DIV_W_MAX = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_PEND  = 2'd2;

  // Number of high cycles in one divided period: odd ratios get the extra cycle.
  function automatic logic [DIV_W_MAX-1:0] ceil_half(input logic [DIV_W_MAX-1:0] ratio);
    logic [DIV_W_MAX:0] w_sum;
    w_sum = {1'b0, ratio} + {{DIV_W_MAX{1'b0}}, 1'b1};
    return w_sum[DIV_W_MAX:1];
  endfunction

endpackage

// File: rtl/fsic_clkdiv_ch.sv
// One divider channel: free-running modulo counter with registered divided
// clock and period-start strobe, plus a load port used for glitch-free ratio swaps.
module fsic_clkdiv_ch
  import fsic_clk_pkg::*;
#(
  parameter int pDIV_WIDTH = 4,
  parameter int pDEF_RATIO = 4
) (
  input  logic                  ioclk,
  input  logic                  resetb,
  input  logic                  i_run,
  input  logic                  i_load,
  input  logic [pDIV_WIDTH-1:0] i_ratio,
  output logic                  o_div,
  output logic                  o_ce,
  output logic                  o_tc,
  output logic                  o_zero,
  output logic [pDIV_WIDTH-1:0] o_ratio
);

  logic [pDIV_WIDTH-1:0] r_cnt;
  logic [pDIV_WIDTH-1:0] r_ratio;
  logic                  r_div;
  logic                  r_ce;
  logic [DIV_W_MAX-1:0]  w_cnt_ext;
  logic [DIV_W_MAX-1:0]  w_half;

  assign w_cnt_ext = DIV_W_MAX'(r_cnt);
  assign w_half    = ceil_half(DIV_W_MAX'(r_ratio));
  assign o_tc      = (r_cnt == (r_ratio - pDIV_WIDTH'(1)));
  assign o_zero    = (r_cnt == '0);
  assign o_div     = r_div;
  assign o_ce      = r_ce;
  assign o_ratio   = r_ratio;

  // A load restarts the count so the new ratio begins on a fresh period.
  always_ff @(posedge ioclk) begin
    if (!resetb) begin
      r_cnt   <= '0;
      r_ratio <= pDIV_WIDTH'(pDEF_RATIO);
    end else begin
      if (i_load) begin
        r_ratio <= i_ratio;
      end
      if (!i_run || i_load || o_tc) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + pDIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge ioclk) begin
    if (!resetb || !i_run) begin
      r_div <= 1'b0;
      r_ce  <= 1'b0;
    end else begin
      r_div <= (w_cnt_ext < w_half);
      r_ce  <= o_zero;
    end
  end

endmodule

// File: rtl/fsic_clkdiv_gen.sv
// Multi-channel clock divider at the FSIC clock root. Ratio updates go through
// a req/ack handshake and are applied to all channels together at a safe boundary.
module fsic_clkdiv_gen
  import fsic_clk_pkg::*;
#(
  parameter int pNUM_CH    = 2,
  parameter int pDIV_WIDTH = 4,
  parameter int pDEF_RATIO = 4,
  parameter int pTMO_WIDTH = 8
) (
  input  logic                            ioclk,
  input  logic                            resetb,
  input  logic                            enable,
  input  logic [pNUM_CH*pDIV_WIDTH-1:0]   cfg_ratio,
  input  logic                            cfg_req,
  output logic                            cfg_ack,
  output logic                            cfg_err,
  output logic [pNUM_CH-1:0]              div_out,
  output logic [pNUM_CH-1:0]              div_ce,
  output logic                            phase_sync,
  output logic [pNUM_CH*pDIV_WIDTH-1:0]   ratio_cur
);

  localparam logic [pTMO_WIDTH-1:0] TMO_MAX = '1;

  logic [1:0]                      r_state;
  logic [pNUM_CH*pDIV_WIDTH-1:0]   r_shadow;
  logic [pTMO_WIDTH-1:0]           r_tmo;
  logic                            r_ack;
  logic                            r_err;
  logic                            r_sync;
  logic                            r_run;
  logic                            w_run;
  logic                            w_bad;
  logic                            w_apply;
  logic                            w_tmo_hit;
  logic [pTMO_WIDTH-1:0]           w_tmo_next;
  logic [pNUM_CH-1:0]              w_div;
  logic [pNUM_CH-1:0]              w_ce;
  logic [pNUM_CH-1:0]              w_tc;
  logic [pNUM_CH-1:0]              w_zero;
  logic [pNUM_CH*pDIV_WIDTH-1:0]   w_ratio;

  // Counters stay parked at 0 for the first enabled cycle so cnt=0 is seen right after enable.
  assign w_run      = enable && r_run;
  assign w_tmo_next = r_tmo + pTMO_WIDTH'(1);
  assign w_tmo_hit  = (w_tmo_next == TMO_MAX);
  assign w_apply    = (r_state == ST_PEND) && ((&w_tc) || !enable || w_tmo_hit);

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < pNUM_CH; i++) begin
      if (r_shadow[i*pDIV_WIDTH +: pDIV_WIDTH] == '0) begin
        w_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge ioclk) begin
    if (!resetb) begin
      r_run  <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_run  <= enable;
      r_sync <= w_run && (&w_zero);
    end
  end

  always_ff @(posedge ioclk) begin
    if (!resetb) begin
      r_state  <= ST_IDLE;
      r_shadow <= '0;
      r_tmo    <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_req) begin
            r_shadow <= cfg_ratio;
            r_state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_bad) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_tmo   <= '0;
            r_state <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (w_apply) begin
            r_ack   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= w_tmo_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < pNUM_CH; g++) begin : g_ch
    fsic_clkdiv_ch #(
      .pDIV_WIDTH (pDIV_WIDTH),
      .pDEF_RATIO (pDEF_RATIO)
    ) u_ch (
      .ioclk   (ioclk),
      .resetb  (resetb),
      .i_run   (w_run),
      .i_load  (w_apply),
      .i_ratio (r_shadow[g*pDIV_WIDTH +: pDIV_WIDTH]),
      .o_div   (w_div[g]),
      .o_ce    (w_ce[g]),
      .o_tc    (w_tc[g]),
      .o_zero  (w_zero[g]),
      .o_ratio (w_ratio[g*pDIV_WIDTH +: pDIV_WIDTH])
    );
  end

  assign cfg_ack    = r_ack;
  assign cfg_err    = r_err;
  assign div_out    = w_div;
  assign div_ce     = w_ce;
  assign phase_sync = r_sync;
  assign ratio_cur  = w_ratio;

endmodule

// File: tb/tb_fsic_clkdiv_gen.sv
// Self-checking bench for fsic_clkdiv_gen: directed scenarios plus random traffic,
// compared every cycle against a time-based reference model (cnt = age mod ratio).
module tb_fsic_clkdiv_gen;

  localparam int TMO_W     = 5;
  localparam int TMO_LIMIT = (1 << TMO_W) - 1;

  logic       ioclk = 1'b0;
  logic       resetb = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] cfg_ratio = 8'h00;
  logic       cfg_req = 1'b0;
  logic       cfg_ack;
  logic       cfg_err;
  logic [1:0] div_out;
  logic [1:0] div_ce;
  logic       phase_sync;
  logic [7:0] ratio_cur;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: channels restart together, so one age counter suffices.
  int mAlive = 0;
  int mAge   = 0;
  int mRatio [2] = '{4, 4};
  int mShadow[2] = '{0, 0};
  int mMode  = 0;
  int mPend  = 0;
  logic [1:0] eDiv = 2'b00;
  logic [1:0] eCe  = 2'b00;
  logic       eSync = 1'b0;
  logic       eAck  = 1'b0;
  logic       eErr  = 1'b0;

  fsic_clkdiv_gen #(
    .pNUM_CH    (2),
    .pDIV_WIDTH (4),
    .pDEF_RATIO (4),
    .pTMO_WIDTH (TMO_W)
  ) dut (
    .ioclk      (ioclk),
    .resetb     (resetb),
    .enable     (enable),
    .cfg_ratio  (cfg_ratio),
    .cfg_req    (cfg_req),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .div_out    (div_out),
    .div_ce     (div_ce),
    .phase_sync (phase_sync),
    .ratio_cur  (ratio_cur)
  );

  always #5 ioclk = ~ioclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs the DUT sees at that edge.
  task automatic modelEdge();
    int  cnt[2];
    bit  allTc;
    bit  allZero;
    bit  apply;
    bit  live;
    if (!resetb) begin
      mAlive = 0; mAge = 0; mRatio = '{4, 4}; mMode = 0; mPend = 0;
      eDiv = 2'b00; eCe = 2'b00; eSync = 1'b0; eAck = 1'b0; eErr = 1'b0;
      return;
    end
    live    = enable && (mAlive != 0);
    allTc   = 1'b1;
    allZero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cnt[i] = (mAlive != 0) ? (mAge % mRatio[i]) : 0;
      if (((cnt[i] + 1) % mRatio[i]) != 0) allTc = 1'b0;
      if (cnt[i] != 0) allZero = 1'b0;
      eCe[i]  = live && (cnt[i] == 0);
      eDiv[i] = live && (2 * cnt[i] < mRatio[i]);
    end
    eSync = live && allZero;
    apply = 1'b0;
    eAck  = 1'b0;
    eErr  = 1'b0;
    case (mMode)
      0: if (cfg_req) begin
           mShadow[0] = int'(cfg_ratio[3:0]);
           mShadow[1] = int'(cfg_ratio[7:4]);
           mMode = 1;
         end
      1: if (mShadow[0] == 0 || mShadow[1] == 0) begin
           eErr  = 1'b1;
           mMode = 0;
         end else begin
           mMode = 2;
           mPend = 0;
         end
      default: begin
        mPend++;
        if (allTc || !enable || mPend == TMO_LIMIT) begin
          apply  = 1'b1;
          eAck   = 1'b1;
          mRatio = mShadow;
          mMode  = 0;
        end
      end
    endcase
    if (!enable) begin
      mAlive = 0; mAge = 0;
    end else if (mAlive == 0 || apply) begin
      mAlive = 1; mAge = 0;
    end else begin
      mAge++;
    end
  endtask

  task automatic applyStimulus(input logic rstbV, input logic enV, input logic reqV,
                               input logic [7:0] cfgV);
    resetb    = rstbV;
    enable    = enV;
    cfg_req   = reqV;
    cfg_ratio = cfgV;
    @(posedge ioclk);
    modelEdge();
    #1;
    checkOutput("div_out",    32'(div_out),    32'(eDiv));
    checkOutput("div_ce",     32'(div_ce),     32'(eCe));
    checkOutput("phase_sync", 32'(phase_sync), 32'(eSync));
    checkOutput("cfg_ack",    32'(cfg_ack),    32'(eAck));
    checkOutput("cfg_err",    32'(cfg_err),    32'(eErr));
    checkOutput("ratio_cur",  32'(ratio_cur),  32'({mRatio[1][3:0], mRatio[0][3:0]}));
  endtask

  task automatic runCycles(input int n, input logic enV);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, enV, 1'b0, cfg_ratio);
  endtask

  initial begin
    logic enR;
    logic [7:0] cfgR;

    $display("[TB] reset and default ratios");
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("reset_ratio", 32'(ratio_cur), 32'h44);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("start_ce_early", 32'(div_ce), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("start_ce", 32'(div_ce), 32'h3);
    checkOutput("start_sync", 32'(phase_sync), 32'h1);
    runCycles(13, 1'b1);

    $display("[TB] ratios ch1=3 ch0=6");
    applyStimulus(1'b1, 1'b1, 1'b1, {4'd3, 4'd6});
    runCycles(40, 1'b1);

    $display("[TB] zero ratio rejected");
    applyStimulus(1'b1, 1'b1, 1'b1, {4'd5, 4'd0});
    applyStimulus(1'b1, 1'b1, 1'b0, {4'd5, 4'd0});
    checkOutput("err_pulse", 32'(cfg_err), 32'h1);
    checkOutput("err_ratio_kept", 32'(ratio_cur), 32'h36);
    runCycles(10, 1'b1);

    $display("[TB] timeout forced apply");
    applyStimulus(1'b1, 1'b1, 1'b1, {4'd15, 4'd14});
    runCycles(20, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, {4'd13, 4'd11});
    runCycles(TMO_LIMIT + 20, 1'b1);
    checkOutput("tmo_ratio", 32'(ratio_cur), 32'hdb);

    $display("[TB] request while disabled");
    runCycles(3, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, {4'd2, 4'd5});
    applyStimulus(1'b1, 1'b0, 1'b0, {4'd2, 4'd5});
    applyStimulus(1'b1, 1'b0, 1'b0, {4'd2, 4'd5});
    checkOutput("dis_ack", 32'(cfg_ack), 32'h1);
    checkOutput("dis_div", 32'(div_out), 32'h0);
    runCycles(20, 1'b1);

    $display("[TB] reset while pending");
    applyStimulus(1'b1, 1'b1, 1'b1, {4'd3, 4'd7});
    applyStimulus(1'b1, 1'b1, 1'b0, {4'd3, 4'd7});
    applyStimulus(1'b0, 1'b1, 1'b0, {4'd3, 4'd7});
    checkOutput("pend_rst_ratio", 32'(ratio_cur), 32'h44);
    checkOutput("pend_rst_ack", 32'(cfg_ack), 32'h0);
    runCycles(10, 1'b1);

    $display("[TB] ratio 1 on ch0");
    applyStimulus(1'b1, 1'b1, 1'b1, {4'd4, 4'd1});
    runCycles(15, 1'b1);
    checkOutput("r1_div", 32'(div_out[0]), 32'h1);
    checkOutput("r1_ce", 32'(div_ce[0]), 32'h1);

    $display("[TB] random traffic");
    enR = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(15) == 0) enR = ~enR;
      cfgR[3:0] = 4'($urandom_range(0, 7));
      cfgR[7:4] = 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(199) != 0), enR, ($urandom_range(4) == 0), cfgR);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
